// File: rtl/rca_share_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder; sum valid SETTLE_CYC edges after accept, held until i_rsp_ready.
// No accepts while busy. Optional completed-op counter o_op_count under RCA_ARB_OPCNT_EN.
module rca_share_arbiter #(
  parameter  int WIDTH      = 45,
  parameter  int NREQ       = 4,
  parameter  int SETTLE_CYC = 3,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_op_a,
  input  logic [NREQ*WIDTH-1:0] i_req_op_b,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [WIDTH:0]       o_rsp_result,
  output logic [IDW-1:0]       o_rsp_id,
  output logic                 o_busy
`ifdef RCA_ARB_OPCNT_EN
  , output logic [15:0]        o_op_count
`endif
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_gnt_id;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_a, r_op_b;

  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW:0]     w_probe;
  logic             w_accept;
  logic [WIDTH:0]   w_adder;
  logic             w_c;

  // Scan offsets high to low so the smallest offset from r_rr_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_probe   = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      w_probe = {1'b0, r_rr_ptr} + (IDW+1)'(i);
      if (w_probe >= NREQ_W) w_probe = w_probe - NREQ_W;
      if (i_req_valid[w_probe[IDW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_probe[IDW-1:0];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_gnt_vld;

  always_comb begin
    w_c     = 1'b0;
    w_adder = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_adder[k] = r_op_a[k] ^ r_op_b[k] ^ w_c;
      w_c        = (r_op_a[k] & r_op_b[k]) | (w_c & (r_op_a[k] ^ r_op_b[k]));
    end
    w_adder[WIDTH] = w_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)        w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == '0)     w_state_nxt = S_RESP;
      S_RESP:   if (i_rsp_ready)     w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is also forced low while reset is asserted.
  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_req_ready = '0;
    if (w_accept && i_rst_n) o_req_ready[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= '0;
      r_gnt_id     <= '0;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_id     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op_a   <= i_req_op_a[w_gnt_idx*WIDTH +: WIDTH];
          r_op_b   <= i_req_op_b[w_gnt_idx*WIDTH +: WIDTH];
          r_gnt_id <= w_gnt_idx;
          r_rr_ptr <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + IDW'(1);
          r_cnt    <= CW'(SETTLE_CYC-1);
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            o_rsp_result <= w_adder;
            o_rsp_id     <= r_gnt_id;
            o_rsp_valid  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: if (i_rsp_ready) o_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef RCA_ARB_OPCNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        o_op_count <= '0;
    else if (o_rsp_valid && i_rsp_ready) o_op_count <= o_op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Randomized bench for rca_share_arbiter against a transaction-timing model, plus literal directed checks.
module tb_rca_share_arbiter;
  localparam int WIDTH = 45, NREQ = 4, SETTLE_CYC = 3, IDW = 2;

  logic                  clk = 1'b0;
  logic                  i_rst_n;
  logic [NREQ-1:0]       i_req_valid, o_req_ready;
  logic [NREQ*WIDTH-1:0] i_req_op_a, i_req_op_b;
  logic                  o_rsp_valid, i_rsp_ready, o_busy;
  logic [WIDTH:0]        o_rsp_result;
  logic [IDW-1:0]        o_rsp_id;

  always #5 clk = ~clk;

  rca_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .SETTLE_CYC(SETTLE_CYC)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op_a(i_req_op_a), .i_req_op_b(i_req_op_b), .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready), .o_rsp_result(o_rsp_result), .o_rsp_id(o_rsp_id), .o_busy(o_busy));

  int checks = 0, failures = 0, cyc = 0;

  // drive-side values, applied at each falling edge
  logic             d_rst_n, d_rsp_ready;
  logic [NREQ-1:0]  d_valid;
  logic [WIDTH-1:0] d_a [NREQ];
  logic [WIDTH-1:0] d_b [NREQ];

  // transaction-level model
  bit               m_busy, m_rsp_vld;
  int               m_ptr, m_wait, m_id, m_g, m_last_g;
  logic [WIDTH-1:0] m_a, m_b;
  logic [WIDTH:0]   m_res;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int model_grant();
    for (int i = 0; i < NREQ; i++)
      if (d_valid[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom % 4)
      0: return ONES;
      1: return '0;
      default: return t[WIDTH-1:0];
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rsp_vld = 0; m_ptr = 0; m_wait = 0; m_id = 0; m_res = '0;
  endtask

  // One cycle: drive at falling edge, compare 1 time unit later, then advance the model
  // to what the next rising edge must produce.
  task automatic tick();
    int g;
    logic [NREQ-1:0] e_rdy;
    @(negedge clk);
    cyc++;
    i_rst_n     = d_rst_n;
    i_rsp_ready = d_rsp_ready;
    i_req_valid = d_valid;
    for (int k = 0; k < NREQ; k++) begin
      i_req_op_a[k*WIDTH +: WIDTH] = d_a[k];
      i_req_op_b[k*WIDTH +: WIDTH] = d_b[k];
    end
    if (!d_rst_n) model_reset();
    #1;
    g = (d_rst_n && !m_busy) ? model_grant() : -1;
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    chk("req_ready",  o_req_ready,  e_rdy);
    chk("busy",       o_busy,       m_busy);
    chk("rsp_valid",  o_rsp_valid,  m_rsp_vld);
    chk("rsp_result", o_rsp_result, m_res);
    chk("rsp_id",     o_rsp_id,     m_id);
    m_last_g = -1;
    if (d_rst_n) begin
      if (!m_busy) begin
        if (g >= 0) begin
          m_a = d_a[g]; m_b = d_b[g]; m_g = g;
          m_ptr = (g + 1) % NREQ; m_busy = 1; m_wait = SETTLE_CYC; m_last_g = g;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_rsp_vld = 1;
          m_res = {1'b0, m_a} + {1'b0, m_b};
          m_id = m_g;
        end
      end else if (d_rsp_ready) begin
        m_rsp_vld = 0; m_busy = 0;
      end
    end
  endtask

  int gq[$], cq[$];
  logic [WIDTH:0] held_res;

  initial begin
    model_reset();
    d_rst_n = 0; d_rsp_ready = 0; d_valid = '1;
    for (int k = 0; k < NREQ; k++) begin d_a[k] = rand_op(); d_b[k] = rand_op(); end

    // reset state, then reset during SETTLE
    repeat (2) tick();
    chk("lit_rst_ready", o_req_ready, 0);
    chk("lit_rst_valid", o_rsp_valid, 0);
    d_rst_n = 1; d_valid = 4'b0001; d_a[0] = 1; d_b[0] = 1;
    tick();
    chk("lit_acc_req0", o_req_ready, 4'b0001);
    d_valid = '0;
    tick();
    chk("lit_busy_settle", o_busy, 1);
    d_rst_n = 0;
    tick();
    chk("lit_midrst_busy", o_busy, 0);
    chk("lit_midrst_result", o_rsp_result, 0);
    d_rst_n = 1;
    repeat (6) tick();
    chk("lit_no_rsp_after_rst", o_rsp_valid, 0);
    d_valid = '1;
    tick();
    chk("lit_regrant_req0", o_req_ready, 4'b0001);
    d_valid = '0; d_rsp_ready = 1;
    repeat (6) tick();

    // single op with carry ripple, latency and backpressure
    d_rsp_ready = 0; d_valid = 4'b0010; d_a[1] = 45'h1FFF_FFFF_FFFF; d_b[1] = 45'h1;
    tick();
    chk("lit_single_ready", o_req_ready, 4'b0010);
    d_valid = '0;
    repeat (3) tick();
    chk("lit_lat_not_yet", o_rsp_valid, 0);
    tick();
    chk("lit_lat_valid", o_rsp_valid, 1);
    chk("lit_single_result", o_rsp_result, 46'h2000_0000_0000);
    chk("lit_single_id", o_rsp_id, 1);
    d_valid = '1;
    repeat (10) begin
      tick();
      chk("lit_bp_ready", o_req_ready, 0);
      chk("lit_bp_result", o_rsp_result, 46'h2000_0000_0000);
      chk("lit_bp_id", o_rsp_id, 1);
    end
    d_rsp_ready = 1;
    tick();
    d_rsp_ready = 0;
    tick();
    chk("lit_resume_req2", o_req_ready, 4'b0100);
    d_valid = '0; d_rsp_ready = 1;
    repeat (6) tick();

    // carry-out, single requester after pointer has moved past it
    d_rsp_ready = 0; d_valid = 4'b0001; d_a[0] = ONES; d_b[0] = ONES;
    tick();
    chk("lit_carry_ready", o_req_ready, 4'b0001);
    d_valid = '0;
    repeat (4) tick();
    chk("lit_carry_result", o_rsp_result, 46'h3FFF_FFFF_FFFE);
    held_res = o_rsp_result;
    chk("lit_carry_msb", held_res[WIDTH], 1);
    d_rsp_ready = 1;
    tick();

    // fairness after reset: strict rotation spaced SETTLE_CYC+2
    d_rst_n = 0;
    tick();
    d_rst_n = 1; d_valid = '1;
    repeat (32) begin
      tick();
      if (o_req_ready != '0) begin
        for (int k = 0; k < NREQ; k++) if (o_req_ready[k]) gq.push_back(k);
        cq.push_back(cyc);
      end
    end
    chk("fair_count_ge6", gq.size() >= 6, 1);
    if (gq.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("fair_order", gq[i], i % NREQ);
      for (int i = 1; i < 6; i++) chk("fair_space", cq[i] - cq[i-1], SETTLE_CYC + 2);
    end

    // randomized traffic; requesters hold valid/operands until granted or dropped
    repeat (4000) begin
      d_rst_n = ($urandom % 500) != 0;
      d_rsp_ready = ($urandom % 3) != 0;
      for (int k = 0; k < NREQ; k++) begin
        if (d_valid[k] && m_last_g != k) begin
          if ($urandom % 24 == 0) d_valid[k] = 1'b0;
        end else begin
          d_valid[k] = ($urandom % 5) < 2;
          if (d_valid[k]) begin d_a[k] = rand_op(); d_b[k] = rand_op(); end
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
